pll_lock_supervisor: RTL and testbench

//  Consumes the lock outputs of the PLL wrapper and turns them into a clean system reset.

---
 rtl/pll_sup_pkg.sv | 25 ++
 rtl/async_bit_sync.sv | 20 ++
 rtl/pll_lock_supervisor.sv | 140 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        RETRY     = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4,
        LOST      = 3'd5,
        FAULT     = 3'd6
    } state_t;

    // Shared timer must reach the largest terminal count minus one.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/async_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level, reset to 0.
module async_bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] flops;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flops <= '0;
        else        flops <= {flops[STAGES-2:0], d};
    end

    assign q = flops[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Turns the PLL lock indication into a qualified system reset with retry,
// loss accounting and a sticky fault after repeated lock timeouts.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned STABLE_CYCLES   = 1024,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 100000,
    parameter int unsigned STDY_RST_CYCLES = 4,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clock_in,
    input  logic             resetn_in,
    input  logic             pll_locked,
    input  logic             clear_fault,
    output logic             stdy_rst,
    output logic             sys_resetn,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] loss_count
);

    localparam int unsigned TW = timer_width(TIMEOUT_CYCLES, STABLE_CYCLES, HOLD_CYCLES,
                                             STDY_RST_CYCLES);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] STDY_LAST   = TW'(STDY_RST_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    logic             lock_s;
    state_t           state, state_next;
    logic [TW-1:0]    timer, timer_next;
    logic [RW-1:0]    retries, retries_next, retries_inc;
    logic [CNT_W-1:0] loss_count_next;
    logic             stdy_rst_next, sys_resetn_next, ready_next, fault_next;

    async_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clock_in),
        .rst_n (resetn_in),
        .d     (pll_locked),
        .q     (lock_s)
    );

    assign retries_inc = retries + RW'(1);

    // State register together with the registered output decodes.
    always_ff @(posedge clock_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state      <= WAIT_LOCK;
            stdy_rst   <= 1'b0;
            sys_resetn <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_next;
            stdy_rst   <= stdy_rst_next;
            sys_resetn <= sys_resetn_next;
            ready      <= ready_next;
            fault      <= fault_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_LOCK: begin
                if (lock_s)                state_next = STABLE;
                else if (timer == TO_LAST) state_next = (retries_inc == RETRY_LIMIT) ? FAULT : RETRY;
            end
            RETRY:     if (timer == STDY_LAST) state_next = WAIT_LOCK;
            STABLE: begin
                if (!lock_s)                   state_next = WAIT_LOCK;
                else if (timer == STABLE_LAST) state_next = HOLD;
            end
            HOLD: begin
                if (!lock_s)                 state_next = LOST;
                else if (timer == HOLD_LAST) state_next = RUN;
            end
            RUN:       if (!lock_s) state_next = LOST;
            LOST:      if (timer == STDY_LAST) state_next = WAIT_LOCK;
            FAULT:     if (clear_fault) state_next = WAIT_LOCK;
            default:   state_next = WAIT_LOCK;
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_comb begin
        stdy_rst_next   = 1'b0;
        sys_resetn_next = 1'b0;
        ready_next      = 1'b0;
        fault_next      = 1'b0;
        case (state_next)
            RETRY, LOST: stdy_rst_next = 1'b1;
            RUN: begin
                sys_resetn_next = 1'b1;
                ready_next      = 1'b1;
            end
            FAULT:       fault_next = 1'b1;
            default:     ;
        endcase
    end

    // Shared timer restarts on every state change; RUN and FAULT need no timing.
    always_comb begin
        timer_next      = timer + TW'(1);
        retries_next    = retries;
        loss_count_next = loss_count;
        if (state_next != state)
            timer_next = '0;
        else if (state == RUN || state == FAULT)
            timer_next = timer;

        if (state == WAIT_LOCK && !lock_s && timer == TO_LAST)
            retries_next = retries_inc;
        if (state_next == LOST || (state == FAULT && clear_fault))
            retries_next = '0;

        if (state_next == LOST && state != LOST && loss_count != '1)
            loss_count_next = loss_count + CNT_W'(1);
    end

    always_ff @(posedge clock_in or negedge resetn_in) begin
        if (!resetn_in) begin
            timer      <= '0;
            retries    <= '0;
            loss_count <= '0;
        end else begin
            timer      <= timer_next;
            retries    <= retries_next;
            loss_count <= loss_count_next;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             resetn;
    logic             pll_locked;
    logic             clear_fault;
    logic             stdy_rst;
    logic             sys_resetn;
    logic             ready;
    logic             fault;
    logic [CNT_W-1:0] loss_count;

    int checks;
    int failures;

    pll_lock_supervisor #(
        .SYNC_STAGES     (2),
        .STABLE_CYCLES   (8),
        .HOLD_CYCLES     (4),
        .TIMEOUT_CYCLES  (32),
        .STDY_RST_CYCLES (4),
        .MAX_RETRIES     (2),
        .CNT_W           (CNT_W)
    ) dut (
        .clock_in    (clk),
        .resetn_in   (resetn),
        .pll_locked  (pll_locked),
        .clear_fault (clear_fault),
        .stdy_rst    (stdy_rst),
        .sys_resetn  (sys_resetn),
        .ready       (ready),
        .fault       (fault),
        .loss_count  (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        pll_locked  = 1'b0;
        clear_fault = 1'b0;
        tick(2);
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        resetn      = 1'b0;
        pll_locked  = 1'b0;
        clear_fault = 1'b0;
        #3;
        check("rst_sys_resetn", int'(sys_resetn), 0);
        check("rst_ready",      int'(ready),      0);
        check("rst_fault",      int'(fault),      0);
        check("rst_stdy_rst",   int'(stdy_rst),   0);
        check("rst_loss_count", int'(loss_count), 0);

        // Lock 5 cycles after release; reset lifts exactly 15 cycles later.
        do_reset();
        tick(5);
        pll_locked = 1'b1;
        tick(14);
        check("lock_pre_sys_resetn", int'(sys_resetn), 0);
        tick(1);
        check("lock_sys_resetn", int'(sys_resetn), 1);
        check("lock_ready",      int'(ready),      1);

        // Loss in RUN.
        pll_locked = 1'b0;
        tick(2);
        check("loss_pre_sys_resetn", int'(sys_resetn), 1);
        tick(1);
        check("loss_sys_resetn", int'(sys_resetn), 0);
        check("loss_ready",      int'(ready),      0);
        check("loss_count_1",    int'(loss_count), 1);
        check("loss_stdy_rst",   int'(stdy_rst),   1);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n += int'(stdy_rst);
        end
        check("loss_stdy_width", n, 4);

        // Single-cycle glitch in STABLE restarts the window.
        do_reset();
        tick(3);
        pll_locked = 1'b1;
        tick(6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(8);
        check("glitch_no_early_run", int'(sys_resetn), 0);
        check("glitch_loss_count",   int'(loss_count), 0);
        check("glitch_stdy_rst",     int'(stdy_rst),   0);
        tick(6);
        check("glitch_pre_sys_resetn", int'(sys_resetn), 0);
        tick(1);
        check("glitch_sys_resetn", int'(sys_resetn), 1);

        // No lock: one retry pulse, then fault after 2*32+4 cycles.
        do_reset();
        n = 0;
        for (int i = 1; i < 68; i++) begin
            tick(1);
            n += int'(stdy_rst);
            if (i == 31) check("to_pre_retry_stdy", int'(stdy_rst), 0);
            if (i == 32) check("to_retry_stdy",     int'(stdy_rst), 1);
            if (i == 67) check("to_pre_fault",      int'(fault),    0);
        end
        tick(1);
        n += int'(stdy_rst);
        check("to_fault",      int'(fault),      1);
        check("to_sys_resetn", int'(sys_resetn), 0);
        check("to_stdy_total", n, 4);

        // Lock is ignored in FAULT; clear_fault returns to WAIT_LOCK.
        pll_locked = 1'b1;
        tick(20);
        check("fault_sticky",       int'(fault),      1);
        check("fault_sys_resetn",   int'(sys_resetn), 0);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check("clear_fault", int'(fault), 0);
        tick(12);
        check("clear_pre_sys_resetn", int'(sys_resetn), 0);
        tick(1);
        check("clear_sys_resetn", int'(sys_resetn), 1);

        // Five losses from RUN saturate the 2-bit counter at 3.
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'b0;
            tick(3);
            check($sformatf("sat_loss_%0d", i), int'(loss_count), (i < 3) ? i + 1 : 3);
            tick(4);
            pll_locked = 1'b1;
            tick(15);
            check($sformatf("sat_run_%0d", i), int'(sys_resetn), 1);
        end

        // Async reset mid-HOLD clears everything immediately.
        pll_locked = 1'b0;
        tick(10);
        pll_locked = 1'b1;
        tick(12);
        check("hold_sys_resetn", int'(sys_resetn), 0);
        check("hold_loss_count", int'(loss_count), 3);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_sys_resetn", int'(sys_resetn), 0);
        check("arst_ready",      int'(ready),      0);
        check("arst_fault",      int'(fault),      0);
        check("arst_stdy_rst",   int'(stdy_rst),   0);
        check("arst_loss_count", int'(loss_count), 0);
        tick(2);
        resetn = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
